// File: rtl/chrono_pkg.sv
// chrono_pkg: shared state enum, digit struct and 7-segment code table for the lap timer
package chrono_pkg;
  typedef enum logic [1:0] {STOPPED, RUN, LAP} state_t;
  typedef struct packed {
    logic [3:0] h_t;
    logic [3:0] h_u;
    logic [3:0] m_t;
    logic [3:0] m_u;
    logic [3:0] s_t;
    logic [3:0] s_u;
    logic [3:0] c_t;
    logic [3:0] c_u;
  } digits_t;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [7:0][3:0] DIG_MAX = {4'd9, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};
  function automatic logic [6:0] seg_encode(input logic [3:0] v);
    return (v <= 4'd9) ? SEG_DIGIT[v] : SEG_DASH;
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit to 7-segment pattern with selectable polarity
module seg7_decode
  import chrono_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  assign seg = ACTIVE_LOW ? seg_encode(bcd) : ~seg_encode(bcd);
endmodule

// File: rtl/chrono_lap_timer.sv
// chrono_lap_timer: prescaled HH:MM:SS:cc stopwatch with lap freeze and direct 7-segment drive
module chrono_lap_timer
  import chrono_pkg::*;
#(
  parameter int CLK_HZ         = 50000000,
  parameter int TICK_HZ        = 100,
  parameter int MAX_HOURS      = 24,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic       running,
  output logic       lap_active,
  output logic       rollover,
  output logic [6:0] disp0,
  output logic [6:0] disp1,
  output logic [6:0] disp2,
  output logic [6:0] disp3,
  output logic [6:0] disp4,
  output logic [6:0] disp5,
  output logic [6:0] disp6,
  output logic [6:0] disp7
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [7:0] HOUR_LAST = 8'(MAX_HOURS - 1);

  state_t state_q, state_d;
  digits_t dig_q, dig_d, latch_q, latch_d, shown;
  logic [PW-1:0] pre_q, pre_d;
  logic lap_q, lap_d, roll_q, roll_d, tick;
  logic [7:0][3:0] cur, nxt, show_v;
  logic [7:0] at_max, hours;
  logic carry, wrap;
  logic [7:0][6:0] seg;

  // prescaler advances only while counting and is zeroed by clear
  always_comb begin
    tick = (state_q != STOPPED) && (pre_q == PRE_LAST);
    pre_d = clear ? '0 : (state_q == STOPPED) ? pre_q : (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
  end

  // ripple the tick through the BCD digits in one cycle; hour wrap uses the full two-digit value
  always_comb begin
    cur = dig_q;
    carry = tick;
    for (int k = 0; k < 8; k++) begin
      at_max[k] = cur[k] == DIG_MAX[k];
      nxt[k] = carry ? (at_max[k] ? 4'd0 : cur[k] + 4'd1) : cur[k];
      carry = carry & at_max[k];
    end
    hours = 8'(cur[7]) * 8'd10 + 8'(cur[6]);
    wrap = tick & (&at_max[5:0]) & (hours == HOUR_LAST);
    dig_d = (clear | wrap) ? '0 : digits_t'(nxt);
    roll_d = wrap & ~clear;
  end

  // run/stop/lap control; start_stop takes precedence over a coincident lap
  always_comb begin
    state_d = state_q;
    lap_d = lap_q;
    latch_d = latch_q;
    if (start_stop) begin
      state_d = (state_q == STOPPED) ? RUN : STOPPED;
    end else if (lap) begin
      case (state_q)
        RUN: begin
          state_d = LAP;
          lap_d = 1'b1;
          latch_d = dig_q;
        end
        LAP: begin
          state_d = RUN;
          lap_d = 1'b0;
        end
        default: lap_d = 1'b0;
      endcase
    end
  end

  // all state registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= STOPPED;
      dig_q <= '0;
      latch_q <= '0;
      pre_q <= '0;
      lap_q <= 1'b0;
      roll_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dig_q <= dig_d;
      latch_q <= latch_d;
      pre_q <= pre_d;
      lap_q <= lap_d;
      roll_q <= roll_d;
    end
  end

  assign running = state_q != STOPPED;
  assign lap_active = lap_q;
  assign rollover = roll_q;
  assign shown = lap_q ? latch_q : dig_q;
  assign show_v = shown;

  for (genvar g = 0; g < 8; g++) begin : g_seg
    seg7_decode #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg (.bcd(show_v[g]), .seg(seg[g]));
  end

  assign disp0 = seg[0];
  assign disp1 = seg[1];
  assign disp2 = seg[2];
  assign disp3 = seg[3];
  assign disp4 = seg[4];
  assign disp5 = seg[5];
  assign disp6 = seg[6];
  assign disp7 = seg[7];
endmodule

// File: tb/tb_chrono_lap_timer.sv
// tb_chrono_lap_timer: directed and random stimulus against an elapsed-centisecond reference model
module tb_chrono_lap_timer;
  localparam int DIV = 2;
  localparam int MAXH = 12;
  localparam int MAXT = MAXH * 360000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_stop = 1'b0;
  logic lap = 1'b0;
  logic clear = 1'b0;
  logic running, lap_active, rollover;
  logic [6:0] disp0, disp1, disp2, disp3, disp4, disp5, disp6, disp7;
  logic [31:0] pv;
  int checks = 0;
  int errors = 0;
  int m_st = 0, m_la = 0, m_p = 0, m_t = 0, m_latch = 0, m_roll = 0;
  int rc;

  always #5 clk = ~clk;

  chrono_lap_timer #(.CLK_HZ(2), .TICK_HZ(1), .MAX_HOURS(MAXH), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .lap(lap), .clear(clear),
    .running(running), .lap_active(lap_active), .rollover(rollover),
    .disp0(disp0), .disp1(disp1), .disp2(disp2), .disp3(disp3),
    .disp4(disp4), .disp5(disp5), .disp6(disp6), .disp7(disp7)
  );

  function automatic int dig(input int t, input int k);
    int cs, s, mi, h;
    cs = t % 100;
    s = (t / 100) % 60;
    mi = (t / 6000) % 60;
    h = t / 360000;
    case (k)
      0: return cs % 10;
      1: return cs / 10;
      2: return s % 10;
      3: return s / 10;
      4: return mi % 10;
      5: return mi / 10;
      6: return h % 10;
      default: return h / 10;
    endcase
  endfunction

  function automatic logic [6:0] segc(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [55:0] disp_exp(input int t);
    logic [55:0] r;
    for (int k = 0; k < 8; k++) r[k*7 +: 7] = segc(dig(t, k));
    return r;
  endfunction

  function automatic logic [31:0] pack_t(input int t);
    logic [31:0] r;
    for (int k = 0; k < 8; k++) r[k*4 +: 4] = 4'(dig(t, k));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("running", 64'(running), 64'(m_st != 0));
    chk("lap_active", 64'(lap_active), 64'(m_la != 0));
    chk("rollover", 64'(rollover), 64'(m_roll != 0));
    chk("display", 64'({disp7, disp6, disp5, disp4, disp3, disp2, disp1, disp0}),
        64'(disp_exp((m_la != 0) ? m_latch : m_t)));
  endtask

  task automatic model_reset();
    m_st = 0; m_la = 0; m_p = 0; m_t = 0; m_latch = 0; m_roll = 0;
  endtask

  task automatic model(input bit ss, input bit lp, input bit cl);
    int old_t;
    bit tk;
    old_t = m_t;
    tk = (m_st != 0) && (m_p == DIV - 1);
    m_roll = 0;
    if (cl) begin
      m_t = 0;
      m_p = 0;
    end else begin
      if (m_st != 0) m_p = (m_p + 1) % DIV;
      if (tk) begin
        m_t = m_t + 1;
        if (m_t == MAXT) begin
          m_t = 0;
          m_roll = 1;
        end
      end
    end
    if (ss) m_st = (m_st == 0) ? 1 : 0;
    else if (lp) begin
      if (m_st == 1) begin
        m_st = 2; m_la = 1; m_latch = old_t;
      end else if (m_st == 2) begin
        m_st = 1; m_la = 0;
      end else m_la = 0;
    end
  endtask

  task automatic step(input bit ss, input bit lp, input bit cl);
    start_stop = ss;
    lap = lp;
    clear = cl;
    @(posedge clk);
    model(ss, lp, cl);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic preset(input int t);
    start_stop = 1'b0;
    lap = 1'b0;
    clear = 1'b0;
    pv = pack_t(t);
    force dut.dig_d = pv;
    @(posedge clk);
    model(1'b0, 1'b0, 1'b0);
    m_t = t;
    #1 release dut.dig_d;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    model_reset();
    check_all();
    reset = 1'b1;
    idle(2);

    step(1'b1, 1'b0, 1'b0);
    idle(20);
    chk("ten_cs", 64'({disp1, disp0}), 64'({7'b1111001, 7'b1000000}));

    step(1'b0, 1'b0, 1'b1);
    idle(12000);
    chk("one_minute", 64'({disp4, disp3, disp2, disp1, disp0}),
        64'({7'b1111001, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}));

    step(1'b0, 1'b0, 1'b1);
    idle(250);
    step(1'b0, 1'b1, 1'b0);
    idle(199);
    chk("lap_frozen", 64'({disp2, disp1, disp0}), 64'({7'b1111001, 7'b0100100, 7'b0010010}));
    chk("lap_flag", 64'(lap_active), 64'd1);
    step(1'b0, 1'b1, 1'b0);
    chk("lap_release", 64'({disp2, disp1, disp0}), 64'({7'b0100100, 7'b0100100, 7'b0010010}));

    step(1'b1, 1'b1, 1'b0);
    chk("ss_beats_lap", 64'({running, lap_active}), 64'd0);

    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    idle(11);
    step(1'b0, 1'b0, 1'b1);
    chk("clear_tick", 64'({running, rollover, disp1, disp0}), 64'({2'b10, 7'b1000000, 7'b1000000}));

    idle(7);
    step(1'b0, 1'b1, 1'b0);
    idle(5);
    step(1'b1, 1'b0, 1'b0);
    chk("lap_stop_held", 64'({running, lap_active}), 64'b01);
    idle(3);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);

    preset(MAXT - 2);
    step(1'b1, 1'b0, 1'b0);
    rc = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0);
      rc += int'(rollover);
    end
    chk("roll_once", 64'(rc), 64'd1);
    preset(9 * 360000 + 359999);
    idle(4);
    chk("hour_ten", 64'({disp7, disp6}), 64'({7'b1111001, 7'b1000000}));
    preset(MAXT - 1);
    step(1'b0, 1'b0, 1'b1);
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      if (i % 400 == 0) preset((i % 800 == 0) ? MAXT - int'($urandom_range(1, 300)) : int'($urandom_range(0, MAXT - 1)));
      step($urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0, $urandom_range(0, 49) == 0);
    end

    if (m_st == 0) step(1'b1, 1'b0, 1'b0);
    preset(347);
    idle(5);
    #2 reset = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b1;
    check_all();
    step(1'b1, 1'b0, 1'b0);
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
